// File: rtl/log2_fract.sv
// log2_fract
// ----------
// Front stage of the FLOG bfloat16 pipeline. Unpacks one bfloat16 operand,
// classifies special values and produces a fixed-point log2:
//   integer_o : unbiased exponent (two's complement)
//   log_f_o   : fractional bits of log2(1.mant), MSB weight 2^-1
// The fraction comes from a square-and-compare iteration on the mantissa,
// one result bit per cycle.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active low
//   valid_i   : operand valid (accepted when ready_o is high)
//   data_i    : bfloat16 operand {sign, exp, mant}
//   ready_o   : high only while idle
//   integer_o : exp - BIAS, truncated to EXP_WIDTH bits
//   log_f_o   : fraction of log2(1.mant)
//   special_o : 00 normal, 01 -inf, 10 +inf, 11 NaN
//   valid_o   : one-cycle result strobe
module log2_fract #(
    parameter int EXP_WIDTH   = 8,
    parameter int FRACT_WIDTH = 7,
    parameter int BIAS        = 127,
    parameter int GUARD       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_i,
    input  logic [EXP_WIDTH+FRACT_WIDTH:0] data_i,
    output logic                        ready_o,
    output logic signed [EXP_WIDTH-1:0] integer_o,
    output logic [FRACT_WIDTH-1:0]      log_f_o,
    output logic [1:0]                  special_o,
    output logic                        valid_o
);

    localparam int YW = 1 + FRACT_WIDTH + GUARD;   // 1.x mantissa register
    localparam int SW = 2 * YW;                    // 2.x square, never overflows
    localparam int CW = $clog2(FRACT_WIDTH + 1);

    localparam logic [1:0] SP_NORM = 2'b00;
    localparam logic [1:0] SP_NINF = 2'b01;
    localparam logic [1:0] SP_PINF = 2'b10;
    localparam logic [1:0] SP_NAN  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Operand classification.
    function automatic logic [1:0] classify(input logic sgn,
                                            input logic [EXP_WIDTH-1:0] e,
                                            input logic [FRACT_WIDTH-1:0] m);
        logic [1:0] r;
        if (&e) begin
            if (m != '0)     r = SP_NAN;
            else if (!sgn)   r = SP_PINF;
            else             r = SP_NAN;
        end else if (e == '0) begin
            r = SP_NINF;
        end else if (sgn) begin
            r = SP_NAN;
        end else begin
            r = SP_NORM;
        end
        return r;
    endfunction

    // Unbiased exponent, wrapped to EXP_WIDTH bits.
    function automatic logic signed [EXP_WIDTH-1:0] unbias(input logic [EXP_WIDTH-1:0] e);
        return EXP_WIDTH'(int'(e) - BIAS);
    endfunction

    // One square-and-compare step. Returns {result_bit, next_y}; next_y is
    // s/2 when s >= 2, else s, truncated back to the 1.x register width.
    function automatic logic [YW:0] sq_step(input logic [YW-1:0] y);
        logic [SW-1:0] s;
        logic [YW-1:0] yn;
        s = SW'(y) * SW'(y);
        if (s[SW-1]) yn = YW'(s >> YW);
        else         yn = YW'(s >> (YW - 1));
        return {s[SW-1], yn};
    endfunction

    state_t                        state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [YW-1:0]                 y_q, y_d;
    logic [FRACT_WIDTH-1:0]        acc_q, acc_d;
    logic signed [EXP_WIDTH-1:0]   int_acc_q, int_acc_d;
    logic [1:0]                    sp_acc_q, sp_acc_d;
    logic signed [EXP_WIDTH-1:0]   integer_q, integer_d;
    logic [FRACT_WIDTH-1:0]        log_f_q, log_f_d;
    logic [1:0]                    special_q, special_d;
    logic                          valid_q, valid_d;

    logic                          sgn;
    logic [EXP_WIDTH-1:0]          exp_f;
    logic [FRACT_WIDTH-1:0]        mant_f;
    logic [1:0]                    cls;
    logic [YW:0]                   step;

    assign sgn    = data_i[EXP_WIDTH+FRACT_WIDTH];
    assign exp_f  = data_i[EXP_WIDTH+FRACT_WIDTH-1:FRACT_WIDTH];
    assign mant_f = data_i[FRACT_WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        acc_d     = acc_q;
        int_acc_d = int_acc_q;
        sp_acc_d  = sp_acc_q;
        integer_d = integer_q;
        log_f_d   = log_f_q;
        special_d = special_q;
        valid_d   = 1'b0;
        cls       = classify(sgn, exp_f, mant_f);
        step      = sq_step(y_q);

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    sp_acc_d = cls;
                    acc_d    = '0;
                    if (cls != SP_NORM) begin
                        int_acc_d = '0;
                        state_d   = OUT;
                    end else begin
                        int_acc_d = unbias(exp_f);
                        y_d       = {1'b1, mant_f, {GUARD{1'b0}}};
                        cnt_d     = '0;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                // First bit produced ends up in the MSB after all shifts.
                y_d   = step[YW-1:0];
                acc_d = {acc_q[FRACT_WIDTH-2:0], step[YW]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(FRACT_WIDTH - 1)) state_d = OUT;
            end
            OUT: begin
                valid_d   = 1'b1;
                integer_d = int_acc_q;
                log_f_d   = acc_q;
                special_d = sp_acc_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            y_q       <= '0;
            acc_q     <= '0;
            int_acc_q <= '0;
            sp_acc_q  <= SP_NORM;
            integer_q <= '0;
            log_f_q   <= '0;
            special_q <= SP_NORM;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            acc_q     <= acc_d;
            int_acc_q <= int_acc_d;
            sp_acc_q  <= sp_acc_d;
            integer_q <= integer_d;
            log_f_q   <= log_f_d;
            special_q <= special_d;
            valid_q   <= valid_d;
        end
    end

    assign ready_o   = (state_q == IDLE);
    assign integer_o = integer_q;
    assign log_f_o   = log_f_q;
    assign special_o = special_q;
    assign valid_o   = valid_q;

endmodule

// File: tb/tb_log2_fract.sv
module tb_log2_fract;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [15:0] data_i;
    logic        ready_o;
    logic [7:0]  integer_o;
    logic [6:0]  log_f_o;
    logic [1:0]  special_o;
    logic        valid_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    log2_fract dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .ready_o  (ready_o),
        .integer_o(integer_o),
        .log_f_o  (log_f_o),
        .special_o(special_o),
        .valid_o  (valid_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: classification rules and log2 fraction by repeated squaring
    // of the value 1.mant, held as an integer scaled by 2^11 (12 bits kept).
    function automatic void model(input logic [15:0] d, output logic [7:0] ei,
                                  output logic [6:0] ef, output logic [1:0] es);
        int     e, m, fv;
        bit     s;
        longint y, sq;
        e = int'(d[14:7]);
        m = int'(d[6:0]);
        s = d[15];
        ei = 8'h00;
        ef = 7'h00;
        fv = 0;
        if (e == 255)       es = (m == 0 && !s) ? 2'b10 : 2'b11;
        else if (e == 0)    es = 2'b01;
        else if (s)         es = 2'b11;
        else begin
            es = 2'b00;
            ei = 8'((e - 127) & 255);
            y  = longint'(128 + m) * 16;          // value * 2048
            for (int k = 0; k < 7; k++) begin
                sq = y * y;                        // value^2 * 2^22
                if (sq >= (longint'(2) << 22)) begin
                    fv = fv * 2 + 1;
                    y  = sq / 4096;                // (value^2 / 2) * 2048
                end else begin
                    fv = fv * 2;
                    y  = sq / 2048;
                end
            end
            ef = 7'(fv);
        end
    endfunction

    // Issue one operand; return once valid_o is seen. With chain=1 the
    // caller issues the next operand in the very cycle ready_o returns.
    task automatic do_op(input logic [15:0] d, input bit noise, input bit chain);
        logic [7:0] ei;
        logic [6:0] ef;
        logic [1:0] es;
        int  lat;
        bit  busy_ok;
        model(d, ei, ef, es);
        chk("ready_before_accept", ready_o, 1);
        valid_i = 1'b1;
        data_i  = d;
        @(posedge clk);
        #1;
        if (noise) begin
            valid_i = 1'($urandom);
            data_i  = 16'($urandom);
        end else begin
            valid_i = 1'b0;
        end
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 20) begin
            @(negedge clk);
            if (valid_o) break;
            if (ready_o) busy_ok = 1'b0;
            lat++;
            if (noise) begin
                valid_i = 1'($urandom);
                data_i  = 16'($urandom);
            end
        end
        valid_i = 1'b0;
        if (lat >= 20) begin
            chk("valid_timeout", 0, 1);
            return;
        end
        chk("latency", lat, (es == 2'b00) ? 8 : 1);
        chk("ready_low_busy", busy_ok, 1);
        chk("integer", integer_o, ei);
        chk("log_f", log_f_o, ef);
        chk("special", special_o, es);
        chk("ready_with_valid", ready_o, 1);
        if (!chain) begin
            @(negedge clk);
            chk("valid_one_cycle", valid_o, 0);
            chk("integer_hold", integer_o, ei);
        end
    endtask

    initial begin
        bit quiet;
        rst     = 1'b0;
        valid_i = 1'b0;
        data_i  = 16'h0000;
        #3;
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_integer", integer_o, 0);
        chk("rst_log_f", log_f_o, 0);
        chk("rst_special", special_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed normal operands
        do_op(16'h3F80, 0, 0);
        chk("one_int", integer_o, 8'h00);
        chk("one_frac", log_f_o, 7'h00);
        do_op(16'h3FC0, 0, 0);
        chk("onehalf_frac", log_f_o, 7'h4A);
        do_op(16'h4000, 0, 0);
        chk("two_int", integer_o, 8'h01);
        do_op(16'h3F00, 0, 0);
        chk("half_int", integer_o, 8'hFF);
        do_op(16'h0080, 0, 0);
        chk("minnorm_int", integer_o, 8'h82);
        do_op(16'h7F7F, 1, 0);
        chk("maxexp_int", integer_o, 8'h7F);
        do_op(16'h3FFF, 1, 0);

        // Specials
        do_op(16'h0000, 0, 0);
        chk("zero_sp", special_o, 2'b01);
        do_op(16'h8000, 0, 0);
        do_op(16'h7F80, 0, 0);
        chk("pinf_sp", special_o, 2'b10);
        do_op(16'hFF80, 0, 0);
        do_op(16'h7FC1, 1, 0);
        do_op(16'hBF80, 0, 0);
        chk("negnum_sp", special_o, 2'b11);

        // Back-to-back with busy-time noise
        do_op(16'h4040, 1, 1);
        do_op(16'h3FC0, 1, 1);
        do_op(16'h0000, 1, 1);
        do_op(16'h7F80, 1, 1);
        do_op(16'h40A0, 1, 0);

        // Reset during the third iteration aborts the operand
        do_op(16'h3FC0, 0, 0);
        valid_i = 1'b1;
        data_i  = 16'h4040;
        @(posedge clk);
        #1 valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_valid", valid_o, 0);
        chk("abort_ready", ready_o, 1);
        chk("abort_integer", integer_o, 0);
        chk("abort_log_f", log_f_o, 0);
        chk("abort_special", special_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        quiet = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (valid_o) quiet = 1'b0;
        end
        chk("abort_no_valid", quiet, 1);
        do_op(16'h3FC0, 0, 0);

        // Randomized operands, exponent biased toward the edges sometimes
        for (int i = 0; i < 60; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            case ($urandom_range(0, 5))
                0: d[14:7] = 8'h00;
                1: d[14:7] = 8'hFF;
                2: d[14:7] = 8'(127);
                default: ;
            endcase
            if ($urandom_range(0, 2) != 0) d[15] = 1'b0;
            do_op(d, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/log2_fract.md
Name: log2_fract

Overview:
- Front stage of the FLOG bfloat16 pipeline; sits directly upstream of the int-to-float normaliser.
- Accepts one bfloat16 operand and unpacks it. Classifies special values.
- Produces the fixed-point log2 result as a signed integer part (unbiased exponent) plus a FRACT_WIDTH-bit fraction.
- The fraction comes from an iterative square-and-compare on the mantissa, one bit per cycle.
- integer_o, log_f_o and valid_o feed the normaliser's integer, fraction and valid inputs directly.

Parameters:
- EXP_WIDTH, 8, exponent field width and width of integer_o.
- FRACT_WIDTH, 7, mantissa field width, width of log_f_o, and iteration count.
- BIAS, 127, exponent bias.
- GUARD, 4, extra LSBs carried in the internal mantissa register for squaring accuracy.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- valid_i  input  1  operand valid.
- data_i  input  1+EXP_WIDTH+FRACT_WIDTH  bfloat16 operand {sign, exp, mant}.
- ready_o  output  1  block can accept an operand.
- integer_o  output  EXP_WIDTH  two's-complement exp - BIAS.
- log_f_o  output  FRACT_WIDTH  fractional bits of log2(1.mant), MSB = 2^-1.
- special_o  output  2  00 normal, 01 -inf, 10 +inf, 11 NaN.
- valid_o  output  1  one-cycle result strobe.

Behaviour:
- Reset (rst=0, async): state=IDLE; ready_o=1; valid_o=0; integer_o=0; log_f_o=0; special_o=00; iteration counter=0; mantissa register=0.
- Reset asserted mid-operation aborts the operation. No valid_o is produced for the aborted operand.
- Handshake: an operand is accepted on a rising edge with valid_i=1 and ready_o=1.
- ready_o=1 only in IDLE. valid_i outside IDLE is ignored, with no queueing. There is no downstream backpressure.
- FSM IDLE:
  - On accept, classify the operand:
    - exp=all-ones with mant≠0 → NaN.
    - exp=all-ones with mant=0 and sign=0 → +inf.
    - exp=all-ones with mant=0 and sign=1 → NaN.
    - exp=0 (zero or denormal, either sign) → -inf.
    - sign=1 otherwise → NaN.
  - Special operand: latch special_o, force integer_o=0 and log_f_o=0, go to OUT.
  - Normal operand: latch integer_o=exp-BIAS, truncated to EXP_WIDTH (range -126..+127). Load y={1,mant,GUARD zeros}, an unsigned 1.x fixed-point value. Clear the counter. Go to CALC.
- FSM CALC, one iteration per cycle:
  - s=y*y, an unsigned 2.x product.
  - If s≥2: next bit=1 and y=s/2. Else: next bit=0 and y=s.
  - Truncate y back to 1+FRACT_WIDTH+GUARD bits. No rounding.
  - Shift the bit into log_f from the LSB side, so the first bit ends in the MSB.
  - After FRACT_WIDTH iterations go to OUT.
- FSM OUT: valid_o=1 for exactly this cycle. Next state IDLE with ready_o=1.
- Latency, counted in cycles from the accept edge to the valid_o-high cycle: FRACT_WIDTH+1 (8 at defaults) for normal operands, 1 for special operands.
- Throughput: at most one operand per FRACT_WIDTH+2 cycles (normal) or per 2 cycles (special).
- integer_o, log_f_o and special_o update only in OUT and hold their values until the next OUT. They are undefined for consumers except while valid_o=1.
- Boundary cases:
  - exp=BIAS gives integer_o=0.
  - mant=0 gives log_f_o=0 (y stays 1.0 for all iterations).
  - exp=1 gives integer_o=0x82 (-126).
  - exp=254 gives integer_o=0x7F.
  - The maximum mantissa 0x7F must not overflow s; size the product to 2*(1+FRACT_WIDTH+GUARD) bits.

Test Plan:
- Reset then data_i=0x3F80 (1.0) → valid_o 8 cycles after accept; integer_o=0x00, log_f_o=0x00, special_o=00.
- data_i=0x3FC0 (1.5) → integer_o=0x00, log_f_o=0x4A (0.1001010b), special_o=00; data_i=0x4000 (2.0) → integer_o=0x01, log_f_o=0x00.
- data_i=0x3F00 (0.5) → integer_o=0xFF, log_f_o=0x00; data_i=0x0080 (min normal) → integer_o=0x82.
- Specials, each with valid_o 1 cycle after accept and integer_o=log_f_o=0:
  - 0x0000 → special_o=01.
  - 0x8000 → 01.
  - 0x7F80 → 10.
  - 0xFF80 → 11.
  - 0x7FC1 → 11.
  - 0xBF80 → 11.
- Back-to-back: hold valid_i=1 with two operands → second accepted only when ready_o returns; data_i changes while busy do not affect the first result.
- Drive rst=0 during CALC iteration 3 → outputs cleared immediately, no valid_o; the next operand after release completes normally.
